floppy_seek_ctrl: RTL and testbench
===================================

Name: floppy_seek_ctrl

Overview:
Head-positioning sequencer that sits between the FDC command decoder and the floppy drive model.
- Executes RESTORE, SEEK, STEP-IN and STEP-OUT commands.
- Generates correctly timed step pulses at a programmable step rate.
- Maintains the controller's track register and reports busy/done/error to the command layer.
- Its step outputs wire directly to the drive model's step inputs.

Parameters:
SYS_CLK, 8400000, system clock frequency in Hz; all timings derive from it.
TRACKS, 85, number of physical tracks; maximum reachable track is TRACKS-1.
STEP_PULSE_US, 4, width of each step pulse in microseconds.
RESTORE_MAX, 255, step pulses issued by RESTORE before it gives up.

Ports:
clk  in  1  system clock.
reset_n  in  1  asynchronous active-low reset.
cmd_start  in  1  one-cycle command strobe; accepted only when busy=0.
cmd_op  in  2  0=RESTORE, 1=SEEK, 2=STEP-IN (toward track 0), 3=STEP-OUT (away from track 0).
target_track  in  7  SEEK destination, sampled on accept.
step_rate  in  2  step period: 0=6ms, 1=12ms, 2=20ms, 3=30ms; sampled on accept.
track0  in  1  drive reports head at physical track 0.
step_in  out  1  step pulse; drive moves head toward track 0.
step_out  out  1  step pulse; drive moves head toward higher tracks.
track_reg  out  7  controller's track register.
busy  out  1  command in progress.
done  out  1  one-cycle pulse when a command completes, with or without error.
error  out  1  last command failed; held until the next accepted command.

Behaviour:
Reset values (asynchronous, immediate when reset_n low): step_in=0, step_out=0, track_reg=0, busy=0, done=0, error=0, state=IDLE, all counters=0. Reset mid-command aborts the command with no done pulse.

Derived timing constants:
- PULSE_CLKS = (SYS_CLK/1000000)*STEP_PULSE_US.
- RATE_CLKS = (SYS_CLK/1000)*{6,12,20,30}[step_rate]; the selected rate is latched on accept.

States: IDLE, DECIDE, PULSE, SETTLE, FINISH.

IDLE:
- cmd_start=1 → latch cmd_op, target_track, step_rate; clear error; busy=1; go to DECIDE on the next cycle.
- SEEK target_track > TRACKS-1 is clamped to TRACKS-1 at latch time.

DECIDE (one cycle):
- RESTORE:
  - track0=1 → track_reg=0, go to FINISH.
  - step count = RESTORE_MAX → error=1, go to FINISH; track_reg is unchanged.
  - otherwise → direction=in, step count+1, go to PULSE.
- SEEK:
  - track_reg = target → go to FINISH.
  - target > track_reg → direction=out, track_reg+1.
  - target < track_reg → direction=in, track_reg-1.
  - Then go to PULSE.
- STEP-IN: track_reg-1, saturating at 0. A pulse is still issued at 0. Go to PULSE.
- STEP-OUT: track_reg+1, saturating at TRACKS-1. A pulse is still issued. Go to PULSE.

PULSE:
- The selected step output is high for exactly PULSE_CLKS cycles; the other output stays low.
- The two step outputs are never high simultaneously.
- Then go to SETTLE.

SETTLE:
- Wait until RATE_CLKS cycles have elapsed, measured from the rising edge of the pulse.
- Next state: STEP-IN and STEP-OUT go to FINISH; RESTORE and SEEK go to DECIDE.

FINISH (one cycle):
- done=1, busy=0, go to IDLE.

Handshake and boundaries:
- cmd_start while busy=1 is ignored entirely: no latch, no error.
- Pulse-to-pulse spacing equals RATE_CLKS exactly, plus the one DECIDE cycle.
- track0 is sampled only in DECIDE.
- track_reg updates in the DECIDE cycle, before the pulse is driven.
- Step counter width is 8 bits.

Test Plan:
Use SYS_CLK=1000000 so that PULSE_CLKS=4 and 6 ms = 6000 clocks.
1. Reset: hold reset_n=0 mid-PULSE → step_out drops to 0 in the same cycle, busy=0, track_reg=0; after release, no done pulse occurs.
2. SEEK from 0 to target 3, step_rate=0:
   - Exactly 3 step_out pulses, each 4 clocks wide.
   - Rising edges 6001 clocks apart.
   - track_reg reads 1, 2, 3.
   - done fires once; error=0.
3. RESTORE from track_reg=5 with a drive model asserting track0 after the 5th pulse:
   - 5 step_in pulses, then track_reg=0 and done.
   - With track0 tied low: 255 pulses, then error=1 and done, and error stays high until the next accepted command.
4. SEEK target=100 with TRACKS=85 → target clamps to 84; 84 step_out pulses from track 0.
5. STEP-IN at track_reg=0 → one step_in pulse of 4 clocks; track_reg stays 0; done after 6000 clocks.
6. cmd_start pulsed during a SEEK → ignored: no change to the latched target, no extra done, busy stays high until the original SEEK finishes.

Source files
------------

// File: rtl/floppy_seek_ctrl.sv
// Head-positioning sequencer: runs RESTORE/SEEK/STEP-IN/STEP-OUT, times step pulses, owns the track register.
// Handshake: cmd_start is a one-cycle strobe taken only while busy=0; done pulses once as busy falls; error holds until the next accept.
`timescale 1ns/1ps
module floppy_seek_ctrl #(
    parameter int unsigned SYS_CLK       = 8400000,
    parameter int unsigned TRACKS        = 85,
    parameter int unsigned STEP_PULSE_US = 4,
    parameter int unsigned RESTORE_MAX   = 255
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       cmd_start,
    input  logic [1:0] cmd_op,
    input  logic [6:0] target_track,
    input  logic [1:0] step_rate,
    input  logic       track0,
    output logic       step_in,
    output logic       step_out,
    output logic [6:0] track_reg,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [2:0] o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DECIDE = 3'd1,
        S_PULSE  = 3'd2,
        S_SETTLE = 3'd3,
        S_FINISH = 3'd4
    } state_t;

    localparam int unsigned PULSE_CLKS = (SYS_CLK / 1000000) * STEP_PULSE_US;
    localparam int unsigned RATE_6     = (SYS_CLK / 1000) * 6;
    localparam int unsigned RATE_12    = (SYS_CLK / 1000) * 12;
    localparam int unsigned RATE_20    = (SYS_CLK / 1000) * 20;
    localparam int unsigned RATE_30    = (SYS_CLK / 1000) * 30;
    localparam int          CNT_W      = $clog2(RATE_30 + 1);

    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_CLKS - 1);
    localparam logic [6:0]       MAX_TRK    = 7'(TRACKS - 1);
    localparam logic [7:0]       STEP_LIMIT = 8'(RESTORE_MAX);

    localparam logic [1:0] OP_RESTORE  = 2'd0;
    localparam logic [1:0] OP_SEEK     = 2'd1;
    localparam logic [1:0] OP_STEP_IN  = 2'd2;

    state_t           r_state;
    logic [1:0]       r_op;
    logic [6:0]       r_target;
    logic [1:0]       r_rate;
    logic [CNT_W-1:0] r_cnt;
    logic [7:0]       r_steps;
    logic [6:0]       r_track;
    logic             r_step_in;
    logic             r_step_out;
    logic             r_busy;
    logic             r_done;
    logic             r_error;
    logic [CNT_W-1:0] w_rate_last;

    always_comb begin
        w_rate_last = CNT_W'(RATE_6 - 1);
        case (r_rate)
            2'd0:    w_rate_last = CNT_W'(RATE_6 - 1);
            2'd1:    w_rate_last = CNT_W'(RATE_12 - 1);
            2'd2:    w_rate_last = CNT_W'(RATE_20 - 1);
            default: w_rate_last = CNT_W'(RATE_30 - 1);
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_op       <= 2'd0;
            r_target   <= 7'd0;
            r_rate     <= 2'd0;
            r_cnt      <= '0;
            r_steps    <= 8'd0;
            r_track    <= 7'd0;
            r_step_in  <= 1'b0;
            r_step_out <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                // FINISH already has busy low, so it accepts a new command just like IDLE.
                S_IDLE, S_FINISH: begin
                    if (cmd_start) begin
                        r_op     <= cmd_op;
                        r_target <= (target_track > MAX_TRK) ? MAX_TRK : target_track;
                        r_rate   <= step_rate;
                        r_steps  <= 8'd0;
                        r_error  <= 1'b0;
                        r_busy   <= 1'b1;
                        r_state  <= S_DECIDE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DECIDE: begin
                    r_cnt <= '0;
                    case (r_op)
                        OP_RESTORE: begin
                            if (track0) begin
                                r_track <= 7'd0;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end else if (r_steps == STEP_LIMIT) begin
                                r_error <= 1'b1;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end else begin
                                r_steps   <= r_steps + 8'd1;
                                r_step_in <= 1'b1;
                                r_state   <= S_PULSE;
                            end
                        end
                        OP_SEEK: begin
                            if (r_track == r_target) begin
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                                r_state <= S_FINISH;
                            end else if (r_target > r_track) begin
                                r_track    <= r_track + 7'd1;
                                r_step_out <= 1'b1;
                                r_state    <= S_PULSE;
                            end else begin
                                r_track   <= r_track - 7'd1;
                                r_step_in <= 1'b1;
                                r_state   <= S_PULSE;
                            end
                        end
                        OP_STEP_IN: begin
                            r_track   <= (r_track == 7'd0) ? 7'd0 : r_track - 7'd1;
                            r_step_in <= 1'b1;
                            r_state   <= S_PULSE;
                        end
                        default: begin
                            r_track    <= (r_track == MAX_TRK) ? MAX_TRK : r_track + 7'd1;
                            r_step_out <= 1'b1;
                            r_state    <= S_PULSE;
                        end
                    endcase
                end
                S_PULSE: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == PULSE_LAST) begin
                        r_step_in  <= 1'b0;
                        r_step_out <= 1'b0;
                        r_state    <= S_SETTLE;
                    end
                end
                // r_cnt keeps running from the pulse rise, so the step period includes the pulse.
                S_SETTLE: begin
                    if (r_cnt == w_rate_last) begin
                        if (r_op == OP_RESTORE || r_op == OP_SEEK) begin
                            r_state <= S_DECIDE;
                        end else begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_FINISH;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign step_in     = r_step_in;
    assign step_out    = r_step_out;
    assign track_reg   = r_track;
    assign busy        = r_busy;
    assign done        = r_done;
    assign error       = r_error;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_floppy_seek_ctrl.sv
// Bench for floppy_seek_ctrl: directed commands, a drive head model, and a queue-based monitor for pulses and done.
// TRACKS and RESTORE_MAX are shrunk so every step-counting scenario stays short at 6000 clocks per step.
`timescale 1ns/1ps
module tb_floppy_seek_ctrl;

    localparam int PULSE = 4;
    localparam int RATE0 = 6000;
    localparam int NTRK  = 4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       cmd_start;
    logic [1:0] cmd_op;
    logic [6:0] target_track;
    logic [1:0] step_rate;
    logic       track0;
    logic       step_in;
    logic       step_out;
    logic [6:0] track_reg;
    logic       busy;
    logic       done;
    logic       error;
    logic [2:0] dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // pulse entry: {dir_out, check_gap, track_reg}; done entry: {error, track_reg, clocks since last rise}
    logic [8:0]  exp_pulse_q[$];
    logic [21:0] exp_done_q[$];

    bit mon_en = 1'b0;
    bit t0_low = 1'b0;
    int head   = 0;
    logic p_in = 1'b0, p_out = 1'b0;

    floppy_seek_ctrl #(
        .SYS_CLK(1000000), .TRACKS(NTRK), .STEP_PULSE_US(4), .RESTORE_MAX(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .cmd_start(cmd_start), .cmd_op(cmd_op),
        .target_track(target_track), .step_rate(step_rate), .track0(track0),
        .step_in(step_in), .step_out(step_out), .track_reg(track_reg),
        .busy(busy), .done(done), .error(error), .o_dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    assign track0 = t0_low ? 1'b0 : (head == 0);

    // Drive model: head moves on each step rising edge, bounded by the physical stops.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (step_in && !p_in && head > 0) head = head - 1;
        if (step_out && !p_out && head < NTRK - 1) head = head + 1;
        p_in  = step_in;
        p_out = step_out;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    logic        m_prev = 1'b0;
    int          m_width = 0;
    int          last_rise = 0;
    logic [8:0]  pe;
    logic [21:0] de;

    always @(negedge clk) begin
        if (step_in && step_out) check("step_exclusive", 1, 0);
        if ((step_in || step_out) && !m_prev) begin
            m_width = 1;
            if (mon_en) begin
                if (exp_pulse_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    pe = exp_pulse_q.pop_front();
                    check("pulse_dir_out", int'(step_out), int'(pe[8]));
                    check("pulse_track", int'(track_reg), int'(pe[6:0]));
                    if (pe[7]) check("pulse_gap", cyc - last_rise, RATE0 + 1);
                end
            end
            last_rise = cyc;
        end else if (step_in || step_out) begin
            m_width++;
        end else if (m_prev && mon_en) begin
            check("pulse_width", m_width, PULSE);
        end
        m_prev = step_in || step_out;
        if (done) begin
            if (exp_done_q.size() == 0) begin
                check("unexpected_done", 1, 0);
            end else begin
                de = exp_done_q.pop_front();
                check("done_error", int'(error), int'(de[21]));
                check("done_track", int'(track_reg), int'(de[20:14]));
                check("done_latency", cyc - last_rise, int'(de[13:0]));
                check("busy_at_done", int'(busy), 0);
            end
        end
    end

    task automatic exp_pulse(input bit dir_out, input bit gap, input int trk);
        exp_pulse_q.push_back({dir_out, gap, 7'(trk)});
    endtask

    task automatic exp_done(input bit err, input int trk, input int lat);
        exp_done_q.push_back({err, 7'(trk), 14'(lat)});
    endtask

    task automatic issue(input int op, input int tgt, input int rate);
        int k;
        k = 0;
        while (busy && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check("issue_wait_idle", int'(busy), 0);
        @(negedge clk);
        cmd_op       = 2'(op);
        target_track = 7'(tgt);
        step_rate    = 2'(rate);
        cmd_start    = 1'b1;
        @(posedge clk);
        #1 cmd_start = 1'b0;
        check("busy_after_accept", int'(busy), 1);
        check("error_cleared_on_accept", int'(error), 0);
    endtask

    task automatic wait_done(input string nm);
        int k;
        k = 0;
        while ((exp_done_q.size() != 0 || busy) && k < 40000) begin
            @(negedge clk);
            k++;
        end
        check({nm, "_completed"}, int'(k < 40000), 1);
        check({nm, "_pulses_consumed"}, exp_pulse_q.size(), 0);
    endtask

    initial begin
        int k;
        reset_n      = 1'b0;
        cmd_start    = 1'b0;
        cmd_op       = 2'd0;
        target_track = 7'd0;
        step_rate    = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_step_in", int'(step_in), 0);
        check("rst_step_out", int'(step_out), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        check("rst_error", int'(error), 0);
        check("rst_track", int'(track_reg), 0);
        check("rst_state", int'(dbg_state), 0);
        @(negedge clk);
        reset_n = 1'b1;

        // Reset in the middle of a STEP-OUT pulse.
        issue(3, 0, 0);
        k = 0;
        while (!step_out && k < 10) begin
            @(negedge clk);
            k++;
        end
        check("reset_test_pulse_seen", int'(step_out), 1);
        @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        check("mid_pulse_rst_step_out", int'(step_out), 0);
        check("mid_pulse_rst_busy", int'(busy), 0);
        check("mid_pulse_rst_track", int'(track_reg), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        head    = 0;
        mon_en  = 1'b1;
        repeat (6100) @(negedge clk);
        check("post_reset_idle_busy", int'(busy), 0);

        // STEP-IN at track 0: pulse still issued, track saturates.
        exp_pulse(1'b0, 1'b0, 0);
        exp_done(1'b0, 0, RATE0);
        issue(2, 0, 0);
        wait_done("step_in_at_0");

        // SEEK 0 -> 2 with a stray cmd_start in the middle that must be ignored.
        exp_pulse(1'b1, 1'b0, 1);
        exp_pulse(1'b1, 1'b1, 2);
        exp_done(1'b0, 2, RATE0 + 1);
        issue(1, 2, 0);
        repeat (3000) @(negedge clk);
        cmd_op       = 2'd0;
        target_track = 7'd0;
        step_rate    = 2'd3;
        cmd_start    = 1'b1;
        @(posedge clk);
        #1 cmd_start = 1'b0;
        check("ignored_cmd_busy", int'(busy), 1);
        check("ignored_cmd_error", int'(error), 0);
        wait_done("seek_0_to_2");

        // SEEK beyond the last track clamps to TRACKS-1 = 3.
        exp_pulse(1'b1, 1'b0, 3);
        exp_done(1'b0, 3, RATE0 + 1);
        issue(1, 100, 0);
        wait_done("seek_clamped");
        check("head_at_3", head, 3);

        // RESTORE from track 3: three step-in pulses, track0 seen on the fourth decision.
        exp_pulse(1'b0, 1'b0, 3);
        exp_pulse(1'b0, 1'b1, 3);
        exp_pulse(1'b0, 1'b1, 3);
        exp_done(1'b0, 0, RATE0 + 1);
        issue(0, 0, 0);
        wait_done("restore_ok");
        check("head_at_0", head, 0);

        // RESTORE with track0 stuck low gives up after RESTORE_MAX pulses.
        t0_low = 1'b1;
        exp_pulse(1'b0, 1'b0, 0);
        exp_pulse(1'b0, 1'b1, 0);
        exp_pulse(1'b0, 1'b1, 0);
        exp_done(1'b1, 0, RATE0 + 1);
        issue(0, 0, 0);
        wait_done("restore_fail");
        repeat (500) @(negedge clk);
        check("error_held", int'(error), 1);
        check("error_track_kept", int'(track_reg), 0);
        t0_low = 1'b0;

        // Next accepted command clears error.
        exp_pulse(1'b1, 1'b0, 1);
        exp_done(1'b0, 1, RATE0);
        issue(3, 0, 0);
        wait_done("step_out_after_error");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
